multicycle_alu: RTL

//  Parametrised, handshaked successor to the calculator's combinational ALU.

---
 rtl/alu_pkg.sv | 15 +
 rtl/multicycle_alu_if.sv | 38 +++
 rtl/serial_divider.sv | 66 ++++++
 rtl/multicycle_alu.sv | 133 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the multicycle ALU.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multicycle_alu_if.sv
// Operand/result valid-ready bundle for the multicycle ALU.
// Zero_Flag/Negative_Flag exist only when ALU_STATUS_FLAGS_EN is defined.
interface multicycle_alu_if #(
  parameter int WIDTH = 8
);
  localparam int RES_WIDTH = 2 * WIDTH;

  logic                 In_Valid;
  logic                 In_Ready;
  logic [1:0]           Operation;
  logic [WIDTH-1:0]     Operand_1;
  logic [WIDTH-1:0]     Operand_2;
  logic                 Out_Valid;
  logic                 Out_Ready;
  logic [RES_WIDTH-1:0] Result;
  logic                 Div_By_Zero;
`ifdef ALU_STATUS_FLAGS_EN
  logic                 Zero_Flag;
  logic                 Negative_Flag;
`endif

  modport master (
    output In_Valid, Operation, Operand_1, Operand_2, Out_Ready,
    input  In_Ready, Out_Valid, Result, Div_By_Zero
`ifdef ALU_STATUS_FLAGS_EN
    , input Zero_Flag, Negative_Flag
`endif
  );

  modport slave (
    input  In_Valid, Operation, Operand_1, Operand_2, Out_Ready,
    output In_Ready, Out_Valid, Result, Div_By_Zero
`ifdef ALU_STATUS_FLAGS_EN
    , output Zero_Flag, Negative_Flag
`endif
  );

endinterface

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle over WIDTH cycles.
// done/quotient/remainder are combinational during the final iteration so the caller can latch them on that edge.
module serial_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q;  // dividend shifts out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = ~diff[WIDTH];
    rem_nxt = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], fits};
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == LAST);
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
    end else if (busy_q) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked ADD/SUB/MUL/DIV unit; single-cycle ops plus a serial divider.
// Optional status flags are enabled with `define ALU_STATUS_FLAGS_EN.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int RES_WIDTH = 2 * WIDTH
) (
  input  logic Clock,
  input  logic Reset_n,
  multicycle_alu_if.slave bus
);

  state_t state_q, state_d;

  logic                 in_ready;
  logic                 accept;
  logic                 b_zero;
  logic                 div_start;
  logic                 div_busy;
  logic                 div_done;
  logic [WIDTH-1:0]     div_quo;
  logic [WIDTH-1:0]     div_rem;
  logic [RES_WIDTH-1:0] div_res;

  logic [RES_WIDTH-1:0] a_ext;
  logic [RES_WIDTH-1:0] b_ext;
  logic [RES_WIDTH-1:0] alu_res;
  logic                 alu_neg;

  logic [RES_WIDTH-1:0] res_q;
  logic                 dbz_q;

  assign b_zero    = (bus.Operand_2 == '0);
  assign in_ready  = ((state_q == IDLE) && !div_busy) ||
                     ((state_q == DONE) && bus.Out_Ready);
  assign accept    = bus.In_Valid && in_ready;
  assign div_start = accept && (bus.Operation == OP_DIV) && !b_zero;
  assign div_res   = {div_rem, div_quo};

  serial_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .start     (div_start),
    .dividend  (bus.Operand_1),
    .divisor   (bus.Operand_2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = div_start ? DIV : DONE;
      DIV:  if (div_done) state_d = DONE;
      DONE: begin
        if (bus.Out_Ready) begin
          if (accept) state_d = div_start ? DIV : DONE;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Single-cycle results; the DIV arm only matters for the divide-by-zero case.
  always_comb begin
    a_ext   = {{WIDTH{1'b0}}, bus.Operand_1};
    b_ext   = {{WIDTH{1'b0}}, bus.Operand_2};
    alu_res = '0;
    alu_neg = 1'b0;
    case (bus.Operation)
      OP_ADD: alu_res = a_ext + b_ext;
      OP_SUB: begin
        alu_res = a_ext - b_ext;
        alu_neg = (bus.Operand_1 < bus.Operand_2);
      end
      OP_MUL: alu_res = a_ext * b_ext;
      OP_DIV: alu_res = {bus.Operand_1, {WIDTH{1'b1}}};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      res_q <= '0;
      dbz_q <= 1'b0;
    end else if (accept && !div_start) begin
      res_q <= alu_res;
      dbz_q <= (bus.Operation == OP_DIV);
    end else if (div_done) begin
      res_q <= div_res;
      dbz_q <= 1'b0;
    end
  end

`ifdef ALU_STATUS_FLAGS_EN
  logic zf_q;
  logic nf_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      zf_q <= 1'b0;
      nf_q <= 1'b0;
    end else if (accept && !div_start) begin
      zf_q <= (alu_res == '0);
      nf_q <= alu_neg;
    end else if (div_done) begin
      zf_q <= (div_res == '0);
      nf_q <= 1'b0;
    end
  end

  assign bus.Zero_Flag     = zf_q;
  assign bus.Negative_Flag = nf_q;
`else
  logic unused_neg;
  assign unused_neg = alu_neg;
`endif

  assign bus.In_Ready    = in_ready;
  assign bus.Out_Valid   = (state_q == DONE);
  assign bus.Result      = res_q;
  assign bus.Div_By_Zero = dbz_q;

endmodule
